// File: rtl/stopwatch_cu_pkg.sv
// Shared constants and types for the stopwatch control unit.
// State codes are exported as localparams so LEDs and debug tools can decode them.
package stopwatch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_STOP  = 2'b00;
    localparam state_t ST_RUN   = 2'b01;
    localparam state_t ST_CLEAR = 2'b10;

    // 1 kHz sample tick at 100 MHz, 8 ms of stable input to accept a level
    localparam int DB_COUNT_DEF = 100_000;
    localparam int DB_DEPTH_DEF = 8;

    localparam int NUM_BTN   = 3;
    localparam int BTN_RUN   = 0;
    localparam int BTN_CLEAR = 1;
    localparam int BTN_LAP   = 2;

    typedef struct packed {
        logic run;
        logic clear;
    } cu_out_t;

endpackage

// File: rtl/stopwatch_cu_if.sv
// Button/control bundle between the board side and the stopwatch control unit.
// The master side owns the raw buttons; the slave (control unit) owns the controls.
interface stopwatch_cu_if;
    import stopwatch_pkg::*;

    logic   btn_run;
    logic   btn_clear;
    logic   btn_lap;
    logic   run;
    logic   clear;
    logic   lap_hold;
    state_t state;

    modport master (
        output btn_run, btn_clear, btn_lap,
        input  run, clear, lap_hold, state
    );

    modport slave (
        input  btn_run, btn_clear, btn_lap,
        output run, clear, lap_hold, state
    );

endinterface

// File: rtl/stopwatch_cu_btn_debounce.sv
// One button lane: 2-flop synchronizer, sampled shift-register debounce,
// stable level with hysteresis and a registered press pulse on its rising edge.
module btn_debounce #(
    parameter int DB_DEPTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic btn_raw,
    output logic btn_pulse
);

    logic [1:0]          sync_q;
    logic [1:0]          vld_pipe_q;
    logic [DB_DEPTH-1:0] shift_q, shift_d;
    logic                stable_q, stable_d;
    logic                armed_q, armed_d;
    logic                pulse_q, pulse_d;

    // A lane only fires after it has sampled a real low once; a button held
    // through reset settles to stable-high silently and must be re-pressed.
    always_comb begin
        shift_d = shift_q;
        if (sample_tick) shift_d = {shift_q[DB_DEPTH-2:0], sync_q[1]};

        stable_d = stable_q;
        if (&shift_q)       stable_d = 1'b1;
        else if (~|shift_q) stable_d = 1'b0;

        armed_d = armed_q | (sample_tick & vld_pipe_q[1] & ~sync_q[1]);
        pulse_d = stable_d & ~stable_q & armed_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            vld_pipe_q <= '0;
            shift_q    <= '0;
            stable_q   <= 1'b0;
            armed_q    <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_raw};
            vld_pipe_q <= {vld_pipe_q[0], 1'b1};
            shift_q    <= shift_d;
            stable_q   <= stable_d;
            armed_q    <= armed_d;
            pulse_q    <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounces run/clear/lap and sequences the datapath
// through STOP/RUN/CLEAR, driving run, a one-cycle clear and the lap_hold level.
module stopwatch_cu
    import stopwatch_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF,
    parameter int DB_DEPTH = DB_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    stopwatch_cu_if.slave bus
);

    localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

    logic [CW-1:0]      cnt_q;
    logic               sample_tick;
    logic [NUM_BTN-1:0] btn_raw, btn_pulse;
    logic               run_p, clear_p, lap_p;

    state_t  state_q, state_d;
    logic    lap_q, lap_d;
    cu_out_t out_q, out_d;

    // Shared prescaler: every lane samples on the same tick.
    assign sample_tick = (cnt_q == CW'(DB_COUNT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         cnt_q <= '0;
        else if (sample_tick) cnt_q <= '0;
        else                  cnt_q <= cnt_q + CW'(1);
    end

    assign btn_raw[BTN_RUN]   = bus.btn_run;
    assign btn_raw[BTN_CLEAR] = bus.btn_clear;
    assign btn_raw[BTN_LAP]   = bus.btn_lap;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_DEPTH (DB_DEPTH)
        ) u_db (
            .clk         (clk),
            .reset_n     (reset_n),
            .sample_tick (sample_tick),
            .btn_raw     (btn_raw[g]),
            .btn_pulse   (btn_pulse[g])
        );
    end

    assign run_p   = btn_pulse[BTN_RUN];
    assign clear_p = btn_pulse[BTN_CLEAR];
    assign lap_p   = btn_pulse[BTN_LAP];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_STOP;
            lap_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            out_q   <= out_d;
        end
    end

    // Same-cycle pulses resolve clear > run > lap; lap_hold rides along here
    // because its update depends on which pulse won.
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        case (state_q)
            ST_STOP: begin
                if (clear_p) begin
                    state_d = ST_CLEAR;
                    lap_d   = 1'b0;
                end else if (run_p) begin
                    state_d = ST_RUN;
                end else if (lap_p) begin
                    lap_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (run_p)      state_d = ST_STOP;
                else if (lap_p) lap_d   = ~lap_q;
            end
            ST_CLEAR: state_d = ST_STOP;
            default: begin
                state_d = ST_STOP;
                lap_d   = 1'b0;
            end
        endcase
    end

    // Decoding the next state keeps run/clear registered yet aligned with state_q.
    always_comb begin
        out_d       = '0;
        out_d.run   = (state_d == ST_RUN);
        out_d.clear = (state_d == ST_CLEAR);
    end

    assign bus.run      = out_q.run;
    assign bus.clear    = out_q.clear;
    assign bus.lap_hold = lap_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Bench for stopwatch_cu with short debounce timing; directed scenarios plus a
// randomized press sequence checked against an event-level stopwatch model.
module tb_stopwatch_cu;
    import stopwatch_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    stopwatch_cu_if sw_if();

    stopwatch_cu #(
        .DB_COUNT (4),
        .DB_DEPTH (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sw_if.slave)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // cumulative activity counters, sampled on the falling edge
    int n_clear = 0, n_run = 0, n_cst = 0, n_chg = 0;
    logic [1:0] prev_state = 2'b00;

    always @(negedge clk) begin
        if (sw_if.clear === 1'b1) n_clear++;
        if (sw_if.run === 1'b1) n_run++;
        if (sw_if.state === 2'b10) n_cst++;
        if (sw_if.state !== prev_state) n_chg++;
        prev_state = sw_if.state;
    end

    // stopwatch as a user sees it: one accepted press = one event
    logic m_run = 1'b0;
    logic m_lap = 1'b0;
    int   m_clears = 0;

    task automatic model_press(input logic [2:0] m);
        if (m[1] && !m_run) begin
            m_clears++;
            m_lap = 1'b0;
        end else if (m[0]) begin
            m_run = !m_run;
        end else if (m[2]) begin
            m_lap = m_run ? !m_lap : 1'b0;
        end
    endtask

    task automatic drive(input logic [2:0] m);
        sw_if.btn_run   = m[0];
        sw_if.btn_clear = m[1];
        sw_if.btn_lap   = m[2];
    endtask

    task automatic press(input logic [2:0] m, input int hold, input int gap);
        @(posedge clk); #2 drive(m);
        repeat (hold) @(posedge clk);
        #2 drive(3'b000);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        model_press(m);
    endtask

    task automatic glitch(input logic [2:0] m, input int len);
        @(posedge clk); #2 drive(m);
        repeat (len) @(posedge clk);
        #2 drive(3'b000);
        repeat (30) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(3'b000);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (sw_if.state !== 2'b00) $display("FAIL reset_state got=%b exp=00", sw_if.state); else passed++;
        total++; if (sw_if.run !== 1'b0) $display("FAIL reset_run got=%b exp=0", sw_if.run); else passed++;
        total++; if (sw_if.clear !== 1'b0) $display("FAIL reset_clear got=%b exp=0", sw_if.clear); else passed++;
        total++; if (sw_if.lap_hold !== 1'b0) $display("FAIL reset_lap got=%b exp=0", sw_if.lap_hold); else passed++;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        m_run = 1'b0; m_lap = 1'b0;
    endtask

    task automatic test_run_start();
        int c0, k0, lat;
        c0 = n_chg; k0 = n_clear; lat = -1;
        @(posedge clk); #2 drive(3'b001);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sw_if.run === 1'b1 && lat < 0) lat = i;
        end
        total++; if (lat < 0) $display("FAIL start_latency run not seen within 20 cycles"); else passed++;
        total++; if (sw_if.state !== 2'b01) $display("FAIL start_state got=%b exp=01", sw_if.state); else passed++;
        repeat (20) @(posedge clk);
        #2 drive(3'b000);
        repeat (30) @(posedge clk);
        @(negedge clk);
        m_run = 1'b1;
        total++; if (n_chg - c0 !== 1) $display("FAIL start_changes got=%0d exp=1", n_chg - c0); else passed++;
        total++; if (n_clear - k0 !== 0) $display("FAIL start_clear got=%0d exp=0", n_clear - k0); else passed++;
    endtask

    task automatic test_stop_clear();
        int c0, s0;
        press(3'b001, 40, 30);
        total++; if (sw_if.run !== 1'b0) $display("FAIL stop_run got=%b exp=0", sw_if.run); else passed++;
        total++; if (sw_if.state !== 2'b00) $display("FAIL stop_state got=%b exp=00", sw_if.state); else passed++;
        c0 = n_clear; s0 = n_cst;
        press(3'b010, 40, 30);
        total++; if (n_clear - c0 !== 1) $display("FAIL clear_pulse_cycles got=%0d exp=1", n_clear - c0); else passed++;
        total++; if (n_cst - s0 !== 1) $display("FAIL clear_state_cycles got=%0d exp=1", n_cst - s0); else passed++;
        total++; if (sw_if.state !== 2'b00) $display("FAIL clear_back_stop got=%b exp=00", sw_if.state); else passed++;
        total++; if (sw_if.lap_hold !== 1'b0) $display("FAIL clear_lap got=%b exp=0", sw_if.lap_hold); else passed++;
    endtask

    task automatic test_run_ignores_clear();
        int c0;
        press(3'b001, 40, 30);
        total++; if (sw_if.state !== 2'b01) $display("FAIL ign_enter_run got=%b exp=01", sw_if.state); else passed++;
        c0 = n_clear;
        press(3'b010, 40, 30);
        total++; if (n_clear - c0 !== 0) $display("FAIL ign_clear_pulse got=%0d exp=0", n_clear - c0); else passed++;
        total++; if (sw_if.state !== 2'b01) $display("FAIL ign_clear_state got=%b exp=01", sw_if.state); else passed++;
        c0 = n_chg;
        glitch(3'b001, 6);
        total++; if (n_chg - c0 !== 0) $display("FAIL glitch_changes got=%0d exp=0", n_chg - c0); else passed++;
        total++; if (sw_if.state !== 2'b01) $display("FAIL glitch_state got=%b exp=01", sw_if.state); else passed++;
    endtask

    task automatic test_lap();
        press(3'b100, 40, 30);
        total++; if (sw_if.lap_hold !== 1'b1) $display("FAIL lap1 got=%b exp=1", sw_if.lap_hold); else passed++;
        total++; if (sw_if.run !== 1'b1) $display("FAIL lap1_run got=%b exp=1", sw_if.run); else passed++;
        press(3'b100, 40, 30);
        total++; if (sw_if.lap_hold !== 1'b0) $display("FAIL lap2 got=%b exp=0", sw_if.lap_hold); else passed++;
        total++; if (sw_if.run !== 1'b1) $display("FAIL lap2_run got=%b exp=1", sw_if.run); else passed++;
        press(3'b100, 40, 30);
        total++; if (sw_if.lap_hold !== 1'b1) $display("FAIL lap3 got=%b exp=1", sw_if.lap_hold); else passed++;
        press(3'b001, 40, 30);
        total++; if (sw_if.state !== 2'b00) $display("FAIL lap_stop_state got=%b exp=00", sw_if.state); else passed++;
        total++; if (sw_if.lap_hold !== 1'b1) $display("FAIL lap_stop_hold got=%b exp=1", sw_if.lap_hold); else passed++;
        press(3'b100, 40, 30);
        total++; if (sw_if.lap_hold !== 1'b0) $display("FAIL lap_in_stop got=%b exp=0", sw_if.lap_hold); else passed++;
    endtask

    task automatic test_simultaneous();
        int c0, s0, r0;
        c0 = n_clear; s0 = n_cst; r0 = n_run;
        press(3'b011, 40, 30);
        total++; if (n_clear - c0 !== 1) $display("FAIL simul_clear got=%0d exp=1", n_clear - c0); else passed++;
        total++; if (n_cst - s0 !== 1) $display("FAIL simul_clear_state got=%0d exp=1", n_cst - s0); else passed++;
        total++; if (n_run - r0 !== 0) $display("FAIL simul_run_cycles got=%0d exp=0", n_run - r0); else passed++;
        total++; if (sw_if.state !== 2'b00) $display("FAIL simul_state got=%b exp=00", sw_if.state); else passed++;
    endtask

    task automatic test_random();
        int b, c0, mc0;
        logic [2:0] m, g;
        for (int k = 0; k < 14; k++) begin
            b = $urandom_range(0, 2);
            m = 3'b001 << b;
            if ($urandom_range(0, 3) == 0) begin
                g = 3'b001 << $urandom_range(0, 2);
                glitch(g, $urandom_range(1, 6));
            end
            c0 = n_clear; mc0 = m_clears;
            press(m, $urandom_range(25, 45), $urandom_range(30, 45));
            total++; if (sw_if.state !== {1'b0, m_run}) $display("FAIL rand%0d_state btn=%b got=%b exp=%b", k, m, sw_if.state, {1'b0, m_run}); else passed++;
            total++; if (sw_if.lap_hold !== m_lap) $display("FAIL rand%0d_lap btn=%b got=%b exp=%b", k, m, sw_if.lap_hold, m_lap); else passed++;
            total++; if (n_clear - c0 !== m_clears - mc0) $display("FAIL rand%0d_clear btn=%b got=%0d exp=%0d", k, m, n_clear - c0, m_clears - mc0); else passed++;
        end
    endtask

    task automatic test_reset_held();
        int c0;
        if (m_run) press(3'b001, 40, 30);
        @(posedge clk); #2 drive(3'b001);
        repeat (30) @(posedge clk);
        @(negedge clk);
        total++; if (sw_if.state !== 2'b01) $display("FAIL held_enter_run got=%b exp=01", sw_if.state); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++; if (sw_if.run !== 1'b0) $display("FAIL held_async_run got=%b exp=0", sw_if.run); else passed++;
        total++; if (sw_if.state !== 2'b00) $display("FAIL held_async_state got=%b exp=00", sw_if.state); else passed++;
        m_run = 1'b0; m_lap = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        c0 = n_chg;
        repeat (60) @(posedge clk);
        @(negedge clk);
        total++; if (n_chg - c0 !== 0) $display("FAIL held_changes got=%0d exp=0", n_chg - c0); else passed++;
        total++; if (sw_if.state !== 2'b00) $display("FAIL held_state got=%b exp=00", sw_if.state); else passed++;
        #2 drive(3'b000);
        repeat (30) @(posedge clk);
        press(3'b001, 40, 30);
        total++; if (sw_if.state !== 2'b01) $display("FAIL held_repress got=%b exp=01", sw_if.state); else passed++;
    endtask

    initial begin
        drive(3'b000);
        test_reset();
        test_run_start();
        test_stop_clear();
        test_run_ignores_clear();
        test_lap();
        test_simultaneous();
        test_random();
        test_reset_held();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
